// File: rtl/imm_scan_ctrl.sv
// imm_scan_ctrl: raster-order sequencer for the image masking datapath.
//
// For every pixel (i = column, j = row) it reads the frame buffer, hands the
// pixel and its coordinates to the masking unit with a one-cycle Tx strobe,
// and writes the masking result to the VGA buffer, waiting on vga_wr_rdy.
// Per pixel the FSM walks RD -> WAIT -> MASK -> WR (4 cycles minimum, plus
// one cycle for every WR cycle with vga_wr_rdy low).
//
// Build option IMM_WINDOW_ONLY_EN: scan only the MASK_W x MASK_H window at
// the latched offsets, clipped to the frame. A window starting outside the
// frame finishes at once (DONE right after the accepted start).
// Without it the whole frame is scanned and MASK_W/MASK_H only take part in
// the configuration sanity check.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   start, abort           frame request (ignored while busy), frame cancel
//   i_off_in, j_off_in     mask offsets, latched on an accepted start
//   fb_rd_en, fb_addr      frame-buffer read strobe and address (j*IMG_W+i)
//   fb_rd_data             read data, valid the cycle after fb_rd_en
//   m_pixel, m_i_p, m_j_p  pixel and coordinates to the masking unit
//   m_i_off, m_j_off       latched offsets to the masking unit
//   m_tx, m_result         masking strobe, result valid the cycle after m_tx
//   vga_wr_en, vga_addr,   VGA buffer write request, address, data
//   vga_wr_data
//   vga_wr_rdy             write accepted when vga_wr_en && vga_wr_rdy
//   busy, done             frame in progress, end-of-frame pulse
module imm_scan_ctrl #(
   parameter int IMG_W  = 320,
   parameter int IMG_H  = 240,
   parameter int MASK_W = 64,
   parameter int MASK_H = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [8:0]  i_off_in,
   input  logic [7:0]  j_off_in,
   output logic        fb_rd_en,
   output logic [16:0] fb_addr,
   input  logic [11:0] fb_rd_data,
   output logic [11:0] m_pixel,
   output logic [8:0]  m_i_p,
   output logic [7:0]  m_j_p,
   output logic [8:0]  m_i_off,
   output logic [7:0]  m_j_off,
   output logic        m_tx,
   input  logic [11:0] m_result,
   output logic        vga_wr_en,
   output logic [16:0] vga_addr,
   output logic [11:0] vga_wr_data,
   input  logic        vga_wr_rdy,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_MASK, S_WR, S_DONE} state_t;

   // An instance whose geometry does not fit the 9/8-bit coordinates or the
   // 17-bit address finishes every frame without touching either buffer.
   localparam bit CFG_OK = (IMG_W > 0) && (IMG_W <= 512) && (IMG_H > 0) && (IMG_H <= 256) &&
                           (IMG_W * IMG_H <= 131072) && (MASK_W > 0) && (MASK_H > 0);

   state_t      st_q, st_d;
   logic [8:0]  i_q, i_d, ioff_q, ioff_d;
   logic [7:0]  j_q, j_d, joff_q, joff_d;
   logic [11:0] pix_q, pix_d, res_q, res_d;
   logic        first_q, first_d;

   logic [8:0]  i_lo, i_hi, i_start;
   logic [7:0]  j_lo, j_hi, j_start;
   logic        empty;
   logic [16:0] addr;

`ifdef IMM_WINDOW_ONLY_EN
   logic [9:0] i_end;
   logic [8:0] j_end;
   // Window bounds follow the latched offsets; only the start decision looks
   // at the live offset inputs.
   assign i_end   = 10'(ioff_q) + 10'(MASK_W - 1);
   assign j_end   = 9'(joff_q) + 9'(MASK_H - 1);
   assign i_lo    = ioff_q;
   assign j_lo    = joff_q;
   assign i_hi    = (i_end > 10'(IMG_W - 1)) ? 9'(IMG_W - 1) : i_end[8:0];
   assign j_hi    = (j_end > 9'(IMG_H - 1)) ? 8'(IMG_H - 1) : j_end[7:0];
   assign i_start = i_off_in;
   assign j_start = j_off_in;
   assign empty   = !CFG_OK || ({1'b0, i_off_in} >= 10'(IMG_W)) || ({1'b0, j_off_in} >= 9'(IMG_H));
`else
   assign i_lo    = '0;
   assign j_lo    = '0;
   assign i_hi    = 9'(IMG_W - 1);
   assign j_hi    = 8'(IMG_H - 1);
   assign i_start = '0;
   assign j_start = '0;
   assign empty   = !CFG_OK;
`endif

   assign addr = 17'(j_q) * 17'(IMG_W) + 17'(i_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q    <= S_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         ioff_q  <= '0;
         joff_q  <= '0;
         pix_q   <= '0;
         res_q   <= '0;
         first_q <= 1'b0;
      end else begin
         st_q    <= st_d;
         i_q     <= i_d;
         j_q     <= j_d;
         ioff_q  <= ioff_d;
         joff_q  <= joff_d;
         pix_q   <= pix_d;
         res_q   <= res_d;
         first_q <= first_d;
      end
   end

   always_comb begin
      st_d    = st_q;
      i_d     = i_q;
      j_d     = j_q;
      ioff_d  = ioff_q;
      joff_d  = joff_q;
      pix_d   = pix_q;
      res_d   = res_q;
      first_d = first_q;
      case (st_q)
         S_IDLE: begin
            if (start && !abort) begin
               ioff_d = i_off_in;
               joff_d = j_off_in;
               i_d    = i_start;
               j_d    = j_start;
               st_d   = empty ? S_DONE : S_RD;
            end
         end
         S_RD:   st_d = S_WAIT;
         S_WAIT: begin
            pix_d = fb_rd_data;
            st_d  = S_MASK;
         end
         S_MASK: begin
            first_d = 1'b1;
            st_d    = S_WR;
         end
         S_WR: begin
            // m_result is only valid in the first WR cycle; keep it for stalls.
            first_d = 1'b0;
            if (first_q) res_d = m_result;
            if (vga_wr_rdy) begin
               if (i_q == i_hi && j_q == j_hi) begin
                  i_d  = '0;
                  j_d  = '0;
                  st_d = S_DONE;
               end else begin
                  i_d  = (i_q == i_hi) ? i_lo : i_q + 9'd1;
                  j_d  = (i_q == i_hi) ? j_q + 8'd1 : j_q;
                  st_d = S_RD;
               end
            end
         end
         S_DONE:  st_d = S_IDLE;
         default: st_d = S_IDLE;
      endcase
      if (abort) begin
         st_d    = S_IDLE;
         i_d     = '0;
         j_d     = '0;
         first_d = 1'b0;
      end
   end

   assign fb_rd_en    = (st_q == S_RD);
   assign fb_addr     = addr;
   assign m_pixel     = pix_q;
   assign m_i_p       = i_q;
   assign m_j_p       = j_q;
   assign m_i_off     = ioff_q;
   assign m_j_off     = joff_q;
   assign m_tx        = (st_q == S_MASK);
   assign vga_wr_en   = (st_q == S_WR);
   assign vga_addr    = addr;
   assign vga_wr_data = (st_q == S_WR && first_q) ? m_result : res_q;
   assign busy        = (st_q != S_IDLE);
   assign done        = (st_q == S_DONE);

endmodule

// File: tb/tb_imm_scan_ctrl.sv
// tb_imm_scan_ctrl: table-driven and randomized checks of imm_scan_ctrl against a pixel-list model.
module tb_imm_scan_ctrl;
`ifdef IMM_WINDOW_ONLY_EN
   localparam int W = 320, H = 240, NR = 2;
`else
   localparam int W = 4, H = 2, NR = 6;
`endif
   localparam int MW = 64, MH = 64;

   logic        clk = 0, rst_n = 0, start = 0, abort = 0, vga_wr_rdy = 1;
   logic [8:0]  i_off_in = 0;
   logic [7:0]  j_off_in = 0;
   logic [11:0] fb_rd_data = 0, m_result = 0;
   logic        fb_rd_en, m_tx, vga_wr_en, busy, done;
   logic [16:0] fb_addr, vga_addr;
   logic [11:0] m_pixel, vga_wr_data;
   logic [8:0]  m_i_p, m_i_off;
   logic [7:0]  m_j_p, m_j_off;

   imm_scan_ctrl #(.IMG_W(W), .IMG_H(H), .MASK_W(MW), .MASK_H(MH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .i_off_in(i_off_in), .j_off_in(j_off_in),
      .fb_rd_en(fb_rd_en), .fb_addr(fb_addr), .fb_rd_data(fb_rd_data),
      .m_pixel(m_pixel), .m_i_p(m_i_p), .m_j_p(m_j_p), .m_i_off(m_i_off), .m_j_off(m_j_off),
      .m_tx(m_tx), .m_result(m_result),
      .vga_wr_en(vga_wr_en), .vga_addr(vga_addr), .vga_wr_data(vga_wr_data), .vga_wr_rdy(vga_wr_rdy),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   int seed;
   int q_a[$], q_i[$], q_j[$];

   typedef struct {
      logic [8:0] io;
      logic [7:0] jo;
      int sp, sl, ap, ew, el;
      bit ed;
      int ef, elast;
   } vec_t;
   vec_t tbl[5];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [11:0] fbv(input int a);
      return 12'(a * 37 + seed);
   endfunction

   function automatic logic [11:0] mres(input logic [11:0] p, input int i, input int j, input int io, input int jo);
      return p ^ 12'(i * 7 + j * 13 + io + jo * 3);
   endfunction

   // Frame buffer: data for the address read one cycle earlier, noise otherwise.
   initial begin
      logic ren;
      int a;
      ren = 0;
      a = 0;
      forever begin
         @(posedge clk);
         #1;
         fb_rd_data = ren ? fbv(a) : 12'($urandom);
         ren = fb_rd_en;
         a = int'(fb_addr);
      end
   end

   // Masking unit: result one cycle after Tx, noise otherwise.
   initial begin
      logic tx;
      logic [11:0] p;
      int i, j, io, jo;
      tx = 0; p = 0; i = 0; j = 0; io = 0; jo = 0;
      forever begin
         @(posedge clk);
         #1;
         m_result = tx ? mres(p, i, j, io, jo) : 12'($urandom);
         tx = m_tx;
         p = m_pixel;
         i = int'(m_i_p);
         j = int'(m_j_p);
         io = int'(m_i_off);
         jo = int'(m_j_off);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   // Pixel list the controller must visit, in raster order.
   task automatic build(input int io, input int jo);
      int ilo, ihi, jlo, jhi;
      q_a.delete();
      q_i.delete();
      q_j.delete();
`ifdef IMM_WINDOW_ONLY_EN
      ilo = io;
      jlo = jo;
      ihi = (io + MW - 1 < W - 1) ? io + MW - 1 : W - 1;
      jhi = (jo + MH - 1 < H - 1) ? jo + MH - 1 : H - 1;
      if (io >= W || jo >= H) ihi = -1;
`else
      ilo = 0;
      jlo = 0;
      ihi = W - 1;
      jhi = H - 1;
`endif
      for (int j = jlo; j <= jhi; j++)
         for (int i = ilo; i <= ihi; i++) begin
            q_a.push_back(j * W + i);
            q_i.push_back(i);
            q_j.push_back(j);
         end
   endtask

   task automatic run_frame(input int io, input int jo, input int stall_px, input int stall_len,
                            input int abort_px, input bit rnd,
                            output int nwr, output int lat, output bit gd,
                            output int fa, output int la, output int stalls);
      int rd_idx, tx_idx, wr_idx, rem, bound, c;
      bit post_ab, ended;
      build(io, jo);
      rd_idx = 0; tx_idx = 0; wr_idx = 0; rem = stall_len; stalls = 0;
      post_ab = 0; ended = 0; gd = 0; lat = -1; fa = -1; la = -1;
      bound = 8 * q_a.size() + stall_len + 50;
      @(posedge clk);
      #1;
      start = 1; abort = 0; vga_wr_rdy = 1;
      i_off_in = 9'(io); j_off_in = 8'(jo);
      @(posedge clk);
      #1;
      start = 0;
      for (c = 0; c < bound; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #1;
         end
         if (abort) post_ab = 1;
         abort = (abort_px >= 0) && m_tx && (tx_idx == abort_px);
         if (vga_wr_en && wr_idx == stall_px && rem > 0) begin
            vga_wr_rdy = 0;
            rem--;
         end else vga_wr_rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (done || (c == 6 && busy)) begin
            start = 1; i_off_in = 9'd100; j_off_in = 8'd77;
         end else start = 0;
         @(negedge clk);
         if (vga_wr_en && !vga_wr_rdy) stalls++;
         if (post_ab) begin
            chk("abort_idle", {busy, done, fb_rd_en, m_tx, vga_wr_en}, 0);
            chk("abort_ij", {m_i_p, m_j_p}, 0);
            ended = 1;
            break;
         end
         if (fb_rd_en) begin
            if (rd_idx < q_a.size()) chk("rd_addr", fb_addr, q_a[rd_idx]);
            else chk("rd_extra", fb_rd_en, 0);
            rd_idx++;
         end
         if (m_tx) begin
            if (tx_idx < q_a.size()) begin
               chk("m_pixel", m_pixel, fbv(q_a[tx_idx]));
               chk("m_coord", {m_i_p, m_j_p}, {9'(q_i[tx_idx]), 8'(q_j[tx_idx])});
               chk("m_off", {m_i_off, m_j_off}, {9'(io), 8'(jo)});
            end else chk("tx_extra", m_tx, 0);
            tx_idx++;
         end
         if (vga_wr_en) begin
            if (wr_idx < q_a.size()) begin
               chk("wr_addr", vga_addr, q_a[wr_idx]);
               chk("wr_data", vga_wr_data, mres(fbv(q_a[wr_idx]), q_i[wr_idx], q_j[wr_idx], io, jo));
            end else chk("wr_extra", vga_wr_en, 0);
            if (vga_wr_rdy) begin
               if (fa < 0) fa = int'(vga_addr);
               la = int'(vga_addr);
               wr_idx++;
            end
         end
         chk("rd_wr_excl", fb_rd_en && vga_wr_en, 0);
         if (done) begin
            gd = 1;
            lat = c;
            ended = 1;
            break;
         end
         if (!busy) begin
            chk("busy_drop", busy, 1);
            ended = 1;
            break;
         end
      end
      chk("frame_end", ended, 1);
      nwr = wr_idx;
      @(posedge clk);
      #1;
      start = 0; abort = 0; vga_wr_rdy = 1;
      @(negedge clk);
      chk("idle_after", {busy, done, fb_rd_en, vga_wr_en, m_tx}, 0);
   endtask

   initial begin
      int nwr, lat, fa, la, st, io, jo;
      bit gd;
      seed = int'($urandom);
`ifdef IMM_WINDOW_ONLY_EN
      tbl[0] = '{9'd300, 8'd200, -1, 0, -1, 800, 3200, 1'b1, 64300, 76799};
      tbl[1] = '{9'd320, 8'd0, -1, 0, -1, 0, 0, 1'b1, -1, -1};
      tbl[2] = '{9'd10, 8'd5, 3, 5, -1, 4096, 16389, 1'b1, 1610, 21833};
      tbl[3] = '{9'd300, 8'd200, -1, 0, 5, 5, 0, 1'b0, 64300, 64304};
      tbl[4] = '{9'd0, 8'd240, -1, 0, -1, 0, 0, 1'b1, -1, -1};
`else
      tbl[0] = '{9'd3, 8'd1, -1, 0, -1, 8, 32, 1'b1, 0, 7};
      tbl[1] = '{9'd5, 8'd2, 3, 5, -1, 8, 37, 1'b1, 0, 7};
      tbl[2] = '{9'd9, 8'd0, -1, 0, 5, 5, 0, 1'b0, 0, 4};
      tbl[3] = '{9'd0, 8'd0, -1, 0, -1, 8, 32, 1'b1, 0, 7};
      tbl[4] = '{9'd1, 8'd1, 7, 3, -1, 8, 35, 1'b1, 0, 7};
`endif
      repeat (2) @(negedge clk);
      chk("reset_strobes", {fb_rd_en, m_tx, vga_wr_en, busy, done}, 0);
      chk("reset_addr", {fb_addr, vga_addr, m_pixel, vga_wr_data}, 0);
      chk("reset_coord", {m_i_p, m_j_p, m_i_off, m_j_off}, 0);
      #2 rst_n = 1;

      @(posedge clk);
      #1;
      start = 1; abort = 1; i_off_in = 9'd33; j_off_in = 8'd44;
      @(posedge clk);
      #1;
      start = 0; abort = 0;
      @(negedge clk);
      chk("start_abort_idle", {busy, fb_rd_en, done}, 0);
      chk("start_abort_off", {m_i_off, m_j_off}, 0);

      for (int r = 0; r < 5; r++) begin
         run_frame(int'(tbl[r].io), int'(tbl[r].jo), tbl[r].sp, tbl[r].sl, tbl[r].ap, 1'b0,
                   nwr, lat, gd, fa, la, st);
         chk($sformatf("v%0d_writes", r), nwr, tbl[r].ew);
         chk($sformatf("v%0d_done", r), gd, tbl[r].ed);
         if (tbl[r].ed) chk($sformatf("v%0d_latency", r), lat, tbl[r].el);
         chk($sformatf("v%0d_first", r), fa, tbl[r].ef);
         chk($sformatf("v%0d_last", r), la, tbl[r].elast);
      end

      @(posedge clk);
      #1;
      start = 1; i_off_in = 9'd2; j_off_in = 8'd1;
      @(posedge clk);
      #1;
      start = 0; vga_wr_rdy = 0;
      for (int k = 0; k < 20 && !vga_wr_en; k++) begin
         @(posedge clk);
         #1;
      end
      chk("rst_reach_wr", vga_wr_en, 1);
      #2 rst_n = 0;
      #1;
      chk("rst_strobes", {fb_rd_en, m_tx, vga_wr_en, busy, done}, 0);
      chk("rst_addr", {fb_addr, vga_addr, m_pixel, vga_wr_data}, 0);
      chk("rst_coord", {m_i_p, m_j_p, m_i_off, m_j_off}, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_hold", {busy, done}, 0);
      end
      rst_n = 1;
      vga_wr_rdy = 1;

      for (int k = 0; k < NR; k++) begin
`ifdef IMM_WINDOW_ONLY_EN
         io = $urandom_range(0, 330);
         jo = $urandom_range(0, 250);
`else
         io = $urandom_range(0, 511);
         jo = $urandom_range(0, 255);
`endif
         run_frame(io, jo, -1, 0, -1, 1'b1, nwr, lat, gd, fa, la, st);
         chk("rnd_writes", nwr, q_a.size());
         chk("rnd_done", gd, 1);
         chk("rnd_latency", lat, 4 * q_a.size() + st);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
